dmi_jtag_dr_ctrl: RTL and testbench

Data-register controller behind the debug JTAG TAP. It owns the DTMCS (32-bit) and DMI (41-bit) shift registers and sequences DMI read/write requests to the Debug Module over a valid/ready request/response handshake. It tracks sticky DMI error status and services dmireset/dmihardreset. It is driven by the TAP's capture/shift/update strobes and register selects, and sits between the TAP and the DM-side CDC.

---
 rtl/dm_pkg.sv | 42 ++++
 rtl/dmi_jtag_dr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dmi_jtag_dr_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared DTM types, error codes and the DTMCS version for the JTAG DR controller
package dm_pkg;

    localparam logic [3:0] DtmcsVersion = 4'd1;
    localparam int unsigned DmiAbitsDefault = 7;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiNoError = 2'd0,
        DmiFailed  = 2'd2,
        DmiBusy    = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef struct packed {
        logic [DmiAbitsDefault-1:0] address;
        logic [31:0]                data;
        logic [1:0]                 op;
    } dmi_t;

    // Sticky error merge: an existing error is never replaced; only failed/busy responses raise one.
    function automatic logic [1:0] resp_to_error(input logic [1:0] resp, input logic [1:0] err);
        return (err != DmiNoError) ? err :
               (resp == DmiFailed || resp == DmiBusy) ? resp : err;
    endfunction

endpackage

// File: rtl/dmi_jtag_dr_ctrl.sv
// dmi_jtag_dr_ctrl: DTMCS/DMI data registers behind the JTAG TAP, sequencing DMI requests to the DM
// Ports: tck_i/trst_ni clock and async reset; dmi_clear_i sync clear from TestLogicReset;
//        capture_i/shift_i/update_i/tdi_i with dtmcs_select_i/dmi_select_i from the TAP;
//        dtmcs_tdo_o/dmi_tdo_o serial outputs; dmi_rst_no DM-side reset pulse;
//        dmi_req_* request handshake to the DM; dmi_resp_* response handshake from the DM.
module dmi_jtag_dr_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned AbitsWidth = 7,
    parameter int unsigned IdleCycles = 1
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  dmi_clear_i,
    input  logic                  capture_i,
    input  logic                  shift_i,
    input  logic                  update_i,
    input  logic                  tdi_i,
    input  logic                  dtmcs_select_i,
    input  logic                  dmi_select_i,
    output logic                  dtmcs_tdo_o,
    output logic                  dmi_tdo_o,
    output logic                  dmi_rst_no,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [1:0]            dmi_req_op_o,
    output logic [31:0]           dmi_req_data_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [31:0]           dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_resp_i
);

    localparam int unsigned DmiWidth = AbitsWidth + 34;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitReadValid,
        Write,
        WaitWriteValid
    } state_e;

    state_e                r_state;
    logic [1:0]            r_error;
    logic [AbitsWidth-1:0] r_addr;
    logic [31:0]           r_data;
    logic [31:0]           r_dtmcs_sr;
    logic [DmiWidth-1:0]   r_dmi_sr;
    logic                  r_req_valid;
    logic [1:0]            r_req_op;
    logic                  r_dmi_rst_n;

    dtmcs_t                w_dtmcs;
    logic [AbitsWidth-1:0] w_sr_addr;
    logic [31:0]           w_sr_data;
    logic [1:0]            w_sr_op;
    logic                  w_dmi_cap;
    logic                  w_dmi_upd;
    logic                  w_dtmcs_upd;
    logic                  w_hardreset;
    logic                  w_dmireset;
    logic                  w_busy;

    always_comb begin
        w_dtmcs         = '0;
        w_dtmcs.idle    = 3'(IdleCycles);
        w_dtmcs.dmistat = r_error;
        w_dtmcs.abits   = 6'(AbitsWidth);
        w_dtmcs.version = DtmcsVersion;
    end

    assign {w_sr_addr, w_sr_data, w_sr_op} = r_dmi_sr;

    assign w_dmi_cap   = capture_i && dmi_select_i;
    assign w_dmi_upd   = update_i && dmi_select_i;
    assign w_dtmcs_upd = update_i && dtmcs_select_i;
    assign w_hardreset = w_dtmcs_upd && r_dtmcs_sr[17];
    assign w_dmireset  = w_dtmcs_upd && r_dtmcs_sr[16];
    assign w_busy      = r_state != Idle;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state     <= Idle;
            r_error     <= DmiNoError;
            r_addr      <= '0;
            r_data      <= '0;
            r_dtmcs_sr  <= '0;
            r_dmi_sr    <= '0;
            r_req_valid <= 1'b0;
            r_req_op    <= DtmNop;
            r_dmi_rst_n <= 1'b1;
        end else if (dmi_clear_i) begin
            r_state     <= Idle;
            r_error     <= DmiNoError;
            r_addr      <= '0;
            r_data      <= '0;
            r_dtmcs_sr  <= '0;
            r_dmi_sr    <= '0;
            r_req_valid <= 1'b0;
            r_req_op    <= DtmNop;
            r_dmi_rst_n <= 1'b1;
        end else begin
            r_dmi_rst_n <= 1'b1;
            if (dtmcs_select_i) begin
                if (capture_i) r_dtmcs_sr <= w_dtmcs;
                else if (shift_i) r_dtmcs_sr <= {tdi_i, r_dtmcs_sr[31:1]};
            end
            // Capture samples the state before any same-cycle completion, so a busy FSM reports busy.
            if (dmi_select_i) begin
                if (capture_i) r_dmi_sr <= {r_addr, r_data, w_busy ? 2'(DmiBusy) : r_error};
                else if (shift_i) r_dmi_sr <= {tdi_i, r_dmi_sr[DmiWidth-1:1]};
            end
            if (w_hardreset) begin
                r_state     <= Idle;
                r_req_valid <= 1'b0;
                r_req_op    <= DtmNop;
                r_error     <= DmiNoError;
                r_dmi_rst_n <= 1'b0;
            end else begin
                case (r_state)
                    Idle: begin
                        if (w_dmi_upd && r_error == DmiNoError) begin
                            if (w_sr_op == DtmRead) begin
                                r_addr      <= w_sr_addr;
                                r_req_op    <= DtmRead;
                                r_req_valid <= 1'b1;
                                r_state     <= Read;
                            end else if (w_sr_op == DtmWrite) begin
                                r_addr      <= w_sr_addr;
                                r_data      <= w_sr_data;
                                r_req_op    <= DtmWrite;
                                r_req_valid <= 1'b1;
                                r_state     <= Write;
                            end
                        end
                    end
                    Read, Write: begin
                        if (dmi_req_ready_i) begin
                            r_req_valid <= 1'b0;
                            r_req_op    <= DtmNop;
                            r_state     <= (r_state == Read) ? WaitReadValid : WaitWriteValid;
                        end
                    end
                    WaitReadValid, WaitWriteValid: begin
                        if (dmi_resp_valid_i) begin
                            if (r_state == WaitReadValid) r_data <= dmi_resp_data_i;
                            r_error <= resp_to_error(dmi_resp_resp_i, r_error);
                            r_state <= Idle;
                        end
                    end
                    default: r_state <= Idle;
                endcase
                if ((w_dmi_upd || w_dmi_cap) && w_busy && r_error == DmiNoError) r_error <= DmiBusy;
                if (w_dmireset) r_error <= DmiNoError;
            end
        end
    end

    assign dtmcs_tdo_o      = r_dtmcs_sr[0];
    assign dmi_tdo_o        = r_dmi_sr[0];
    assign dmi_rst_no       = r_dmi_rst_n && !dmi_clear_i;
    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_op_o     = r_req_op;
    assign dmi_req_data_o   = r_data;
    assign dmi_resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// tb_dmi_jtag_dr_ctrl: scoreboard bench for the DTMCS/DMI data-register controller
module tb_dmi_jtag_dr_ctrl;

    localparam int AW = 7;
    localparam int DW = AW + 34;

    logic          tck_i = 1'b0;
    logic          trst_ni = 1'b0;
    logic          dmi_clear_i = 1'b0;
    logic          capture_i = 1'b0;
    logic          shift_i = 1'b0;
    logic          update_i = 1'b0;
    logic          tdi_i = 1'b0;
    logic          dtmcs_select_i = 1'b0;
    logic          dmi_select_i = 1'b0;
    logic          dtmcs_tdo_o;
    logic          dmi_tdo_o;
    logic          dmi_rst_no;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i = 1'b1;
    logic [AW-1:0] dmi_req_addr_o;
    logic [1:0]    dmi_req_op_o;
    logic [31:0]   dmi_req_data_o;
    logic          dmi_resp_valid_i = 1'b0;
    logic          dmi_resp_ready_o;
    logic [31:0]   dmi_resp_data_i = '0;
    logic [1:0]    dmi_resp_resp_i = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [63:0] val;
    } word_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [31:0]   data;
    } req_t;

    word_t exp_q[$];
    word_t obs_q[$];
    req_t  req_q[$];
    word_t mon_o;
    word_t mon_e;
    req_t  mon_r;

    dmi_jtag_dr_ctrl #(.AbitsWidth(AW), .IdleCycles(1)) dut (
        .tck_i            (tck_i),
        .trst_ni          (trst_ni),
        .dmi_clear_i      (dmi_clear_i),
        .capture_i        (capture_i),
        .shift_i          (shift_i),
        .update_i         (update_i),
        .tdi_i            (tdi_i),
        .dtmcs_select_i   (dtmcs_select_i),
        .dmi_select_i     (dmi_select_i),
        .dtmcs_tdo_o      (dtmcs_tdo_o),
        .dmi_tdo_o        (dmi_tdo_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i)
    );

    always #5 tck_i = ~tck_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic push_req(input logic [AW-1:0] a, input logic [1:0] op, input logic [31:0] d);
        req_t r;
        r.addr = a;
        r.op = op;
        r.data = d;
        req_q.push_back(r);
    endtask

    // One full capture/shift/update pass; the shifted-out word goes to the scoreboard.
    task automatic access(input bit dmi, input string name, input logic [63:0] exp_cap, input logic [63:0] din);
        int w;
        logic [63:0] got;
        word_t we;
        word_t wo;
        w = dmi ? DW : 32;
        got = '0;
        we.name = name;
        we.val = exp_cap;
        exp_q.push_back(we);
        dtmcs_select_i = !dmi;
        dmi_select_i = dmi;
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        shift_i = 1'b1;
        for (int i = 0; i < w; i++) begin
            tdi_i = din[i];
            got[i] = dmi ? dmi_tdo_o : dtmcs_tdo_o;
            tick();
        end
        shift_i = 1'b0;
        tdi_i = 1'b0;
        wo.name = name;
        wo.val = got;
        obs_q.push_back(wo);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        dtmcs_select_i = 1'b0;
        dmi_select_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] resp);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i = d;
        dmi_resp_resp_i = resp;
        tick();
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, dmi_req_valid_o, 0);
        check({tag, "_op"}, dmi_req_op_o, 0);
        check({tag, "_addr"}, dmi_req_addr_o, 0);
        check({tag, "_data"}, dmi_req_data_o, 0);
        check({tag, "_rst_no"}, dmi_rst_no, 1);
    endtask

    always @(negedge tck_i) begin
        if (obs_q.size() != 0) begin
            mon_o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected capture actual=0x%0h required=none", mon_o.name, mon_o.val);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, mon_o.val, mon_e.val);
            end
        end
        if (trst_ni && dmi_req_valid_o && dmi_req_ready_i) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req actual_op=%0d actual_addr=0x%0h required=none", dmi_req_op_o, dmi_req_addr_o);
            end else begin
                mon_r = req_q.pop_front();
                check("req_op", dmi_req_op_o, mon_r.op);
                check("req_addr", dmi_req_addr_o, mon_r.addr);
                if (mon_r.op == 2'd2) check("req_data", dmi_req_data_o, mon_r.data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        check("reset_dtmcs_tdo", dtmcs_tdo_o, 0);
        check("reset_dmi_tdo", dmi_tdo_o, 0);
        check("resp_ready", dmi_resp_ready_o, 1);
        trst_ni = 1'b1;
        tick();

        access(0, "dtmcs_reset", 64'h1071, 64'h0);

        push_req(7'h10, 2'd2, 32'hDEADBEEF);
        access(1, "cap_write", 64'h0, dmi_word(7'h10, 32'hDEADBEEF, 2'd2));
        check("write_latency_valid", dmi_req_valid_o, 1);
        tick();
        respond(32'h0, 2'd0);

        push_req(7'h11, 2'd1, 32'h0);
        access(1, "cap_after_write", dmi_word(7'h10, 32'hDEADBEEF, 2'd0), dmi_word(7'h11, 32'h0, 2'd1));
        check("read_latency_valid", dmi_req_valid_o, 1);
        tick();
        respond(32'h12345678, 2'd0);
        access(1, "cap_after_read", dmi_word(7'h11, 32'h12345678, 2'd0), 64'h0);

        push_req(7'h05, 2'd1, 32'h0);
        access(1, "cap_before_busy", dmi_word(7'h11, 32'h12345678, 2'd0), dmi_word(7'h05, 32'h0, 2'd1));
        tick();
        access(1, "cap_busy", dmi_word(7'h05, 32'h12345678, 2'd3), 64'h0);
        respond(32'hAAAA5555, 2'd0);
        access(0, "dtmcs_busy", 64'h1C71, 64'h0);
        access(1, "cap_ignored_write", dmi_word(7'h05, 32'hAAAA5555, 2'd3), dmi_word(7'h20, 32'h55, 2'd2));
        check("busy_no_valid_0", dmi_req_valid_o, 0);
        tick();
        check("busy_no_valid_1", dmi_req_valid_o, 0);
        access(0, "dtmcs_busy_clear", 64'h1C71, 64'h10000);
        access(0, "dtmcs_cleared", 64'h1071, 64'h0);

        push_req(7'h06, 2'd1, 32'h0);
        access(1, "cap_before_fail", dmi_word(7'h05, 32'hAAAA5555, 2'd0), dmi_word(7'h06, 32'h0, 2'd1));
        tick();
        respond(32'hFFFF0000, 2'd2);
        access(0, "dtmcs_failed", 64'h1871, 64'h0);
        access(1, "cap_failed", dmi_word(7'h06, 32'hFFFF0000, 2'd2), dmi_word(7'h30, 32'h1, 2'd2));
        check("failed_no_valid", dmi_req_valid_o, 0);
        access(0, "dtmcs_failed_clear", 64'h1871, 64'h10000);
        access(0, "dtmcs_after_dmireset", 64'h1071, 64'h0);

        dmi_req_ready_i = 1'b0;
        access(1, "cap_before_pend", dmi_word(7'h06, 32'hFFFF0000, 2'd0), dmi_word(7'h40, 32'h0BADF00D, 2'd2));
        check("pend_valid", dmi_req_valid_o, 1);
        check("pend_op", dmi_req_op_o, 2);
        check("pend_addr", dmi_req_addr_o, 7'h40);
        check("pend_data", dmi_req_data_o, 32'h0BADF00D);
        access(0, "dtmcs_pend", 64'h1071, 64'h20000);
        check("hard_valid_drop", dmi_req_valid_o, 0);
        check("hard_op_drop", dmi_req_op_o, 0);
        check("hard_rst_low", dmi_rst_no, 0);
        tick();
        check("hard_rst_release", dmi_rst_no, 1);
        check("hard_valid_stays_low", dmi_req_valid_o, 0);
        access(1, "cap_after_hard", dmi_word(7'h40, 32'h0BADF00D, 2'd0), 64'h0);

        dmi_clear_i = 1'b1;
        #1;
        check("clear_rst_low", dmi_rst_no, 0);
        tick();
        dmi_clear_i = 1'b0;
        #1;
        check("clear_rst_release", dmi_rst_no, 1);
        access(1, "cap_after_clear", 64'h0, 64'h0);

        access(1, "cap_pre_trst", 64'h0, dmi_word(7'h50, 32'h11112222, 2'd2));
        check("pre_trst_valid", dmi_req_valid_o, 1);
        #2;
        trst_ni = 1'b0;
        #1;
        check_reset_outputs("trst");
        tick();
        trst_ni = 1'b1;
        dmi_req_ready_i = 1'b1;
        access(0, "dtmcs_after_trst", 64'h1071, 64'h0);

        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size() + req_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
